// File: rtl/kf8259_inta_sequencer.sv
// CPU-side 8259 interrupt-acknowledge sequencer: issues the INTA# pulse train,
// samples the controller's bytes and hands the vector/call address to the core.
module kf8259_inta_sequencer #(
  parameter int INTA_LOW_CYCLES  = 4,
  parameter int INTA_HIGH_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        interrupt_to_cpu,
  input  logic        cpu_interrupt_enable,
  input  logic        mcs80_mode,
  input  logic [7:0]  data_bus_in,
  input  logic        data_bus_drive,
  output logic        interrupt_acknowledge_n,
  output logic        ack_busy,
  output logic        vector_valid,
  input  logic        vector_ready,
  output logic [7:0]  vector,
  output logic [15:0] call_address,
  output logic        spurious
);

  localparam int MAXC = (INTA_LOW_CYCLES > INTA_HIGH_CYCLES) ? INTA_LOW_CYCLES : INTA_HIGH_CYCLES;
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] LOW_LAST  = CW'(INTA_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(INTA_HIGH_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DELIVER} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     pidx_q;
  logic           mcs80_q;
  logic           missing_q;
  logic [7:0]     b0_q, b1_q, b2_q;
  logic           inta_n_q;
  logic           valid_q;
  logic [7:0]     vector_q;
  logic [15:0]    call_q;
  logic           spur_q;

  logic last_pulse, data_bearing, spur_w;

  assign last_pulse   = mcs80_q ? (pidx_q == 2'd2) : (pidx_q == 2'd1);
  // 8086 drives nothing meaningful on the first pulse; MCS-80 drives all three
  assign data_bearing = mcs80_q | (pidx_q == 2'd1);
  assign spur_w       = missing_q | (mcs80_q & (b0_q != 8'hCD));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pidx_q    <= '0;
      mcs80_q   <= 1'b0;
      missing_q <= 1'b0;
      b0_q      <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      inta_n_q  <= 1'b1;
      valid_q   <= 1'b0;
      vector_q  <= '0;
      call_q    <= '0;
      spur_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (interrupt_to_cpu && cpu_interrupt_enable) begin
            state_q   <= LOW;
            inta_n_q  <= 1'b0;
            cnt_q     <= '0;
            pidx_q    <= '0;
            mcs80_q   <= mcs80_mode;
            missing_q <= 1'b0;
            b0_q      <= '0;
            b1_q      <= '0;
            b2_q      <= '0;
          end
        end
        LOW: begin
          if (cnt_q == LOW_LAST) begin
            if (data_bearing) begin
              if (data_bus_drive) begin
                case (pidx_q)
                  2'd0:    b0_q <= data_bus_in;
                  2'd1:    b1_q <= data_bus_in;
                  default: b2_q <= data_bus_in;
                endcase
              end else begin
                missing_q <= 1'b1;
              end
            end
            // INTR withdrawn by the final sample means the request was not genuine
            if (last_pulse && !interrupt_to_cpu) missing_q <= 1'b1;
            state_q  <= HIGH;
            inta_n_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HIGH: begin
          if (cnt_q == HIGH_LAST) begin
            cnt_q <= '0;
            if (!last_pulse) begin
              state_q  <= LOW;
              inta_n_q <= 1'b0;
              pidx_q   <= pidx_q + 1'b1;
            end else begin
              state_q  <= DELIVER;
              valid_q  <= 1'b1;
              spur_q   <= spur_w;
              vector_q <= spur_w ? 8'hFF : b1_q;
              if (spur_w)       call_q <= 16'hFFFF;
              else if (mcs80_q) call_q <= {b2_q, b1_q};
              else              call_q <= {6'b0, b1_q, 2'b00};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DELIVER: begin
          if (vector_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign interrupt_acknowledge_n = inta_n_q;
  assign ack_busy                = (state_q != IDLE);
  assign vector_valid            = valid_q;
  assign vector                  = vector_q;
  assign call_address            = call_q;
  assign spurious                = spur_q;

endmodule

// File: tb/tb_kf8259_inta_sequencer.sv
// Bench for kf8259_inta_sequencer: timeline model checked every cycle plus
// directed sequences with literal expectations.
module tb_kf8259_inta_sequencer;
  localparam int L = 4;
  localparam int H = 4;
  localparam int P = L + H;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        intr = 1'b0, ie = 1'b0, mode = 1'b0, drive = 1'b0, ready = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        inta_n, busy, vector_valid, spurious;
  logic [7:0]  vector;
  logic [15:0] call_address;

  always #5 clock = ~clock;

  kf8259_inta_sequencer #(.INTA_LOW_CYCLES(L), .INTA_HIGH_CYCLES(H)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .interrupt_to_cpu       (intr),
    .cpu_interrupt_enable   (ie),
    .mcs80_mode             (mode),
    .data_bus_in            (data),
    .data_bus_drive         (drive),
    .interrupt_acknowledge_n(inta_n),
    .ack_busy               (busy),
    .vector_valid           (vector_valid),
    .vector_ready           (ready),
    .vector                 (vector),
    .call_address           (call_address),
    .spurious               (spurious)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position on a timeline measured in clocks since the start edge
  int          m_st = 0;   // 0 idle, 1 pulsing, 2 delivering
  int          m_k = 0;
  bit          m_mode = 1'b0;
  logic [7:0]  m_b [3];
  bit          m_miss = 1'b0;
  logic [7:0]  m_vec = 8'h00;
  logic [15:0] m_ca = 16'h0000;
  bit          m_sp = 1'b0;

  always @(posedge clock or posedge reset) begin
    int last, p;
    if (reset) begin
      m_st = 0;
      m_k  = 0;
    end else begin
      case (m_st)
        0: if (intr && ie) begin
          m_st = 1; m_k = 0; m_mode = mode; m_miss = 1'b0;
          m_b[0] = 8'h00; m_b[1] = 8'h00; m_b[2] = 8'h00;
        end
        1: begin
          last = m_mode ? 2 : 1;
          if (m_k % P == L - 1) begin
            p = m_k / P;
            if (m_mode || p == 1) begin
              if (drive) m_b[p] = data;
              else       m_miss = 1'b1;
            end
            if (p == last && !intr) m_miss = 1'b1;
          end
          m_k++;
          if (m_k == (last + 1) * P) begin
            m_st  = 2;
            m_sp  = m_miss || (m_mode && m_b[0] != 8'hCD);
            m_vec = m_sp ? 8'hFF : m_b[1];
            m_ca  = m_sp ? 16'hFFFF : (m_mode ? {m_b[2], m_b[1]} : {6'b0, m_b[1], 2'b00});
          end
        end
        default: if (ready) m_st = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("inta_n", inta_n, (m_st == 1 && (m_k % P) < L) ? 0 : 1);
      chk("ack_busy", busy, m_st != 0);
      chk("vector_valid", vector_valid, m_st == 2);
      if (m_st == 2) begin
        chk("vector", vector, m_vec);
        chk("call_address", call_address, m_ca);
        chk("spurious", spurious, m_sp);
      end
    end
  end

  task automatic run_seq(input bit md, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [2:0] dv, input bit drop,
                         output int lat, output int pulses, output int lows,
                         output logic [7:0] v, output logic [15:0] ca, output logic sp);
    bit prev = 1'b1;
    bit done = 1'b0;
    int pi = 0;
    lat = 0; pulses = 0; lows = 0; v = 8'h00; ca = 16'h0000; sp = 1'b0;
    @(negedge clock);
    intr = 1'b1; ie = 1'b1; mode = md;
    while (!done && lat < 200) begin
      @(negedge clock);
      lat++;
      if (vector_valid) begin
        done = 1'b1; v = vector; ca = call_address; sp = spurious;
        intr = 1'b0; drive = 1'b0; data = 8'h00;
      end else begin
        if (prev && !inta_n) begin pi = pulses; pulses++; end
        prev = inta_n;
        if (!inta_n) begin
          lows++;
          drive = dv[pi[1:0]];
          data  = (pi == 0) ? b0 : (pi == 1) ? b1 : b2;
        end else begin
          drive = 1'b0; data = 8'h00;
        end
        // late changes to mode/enable must not disturb a running sequence
        if (pulses >= 1) begin mode = ~md; ie = 1'b0; end
        if (drop && pulses >= 1 && inta_n) intr = 1'b0;
      end
    end
    chk("seq_done", done, 1'b1);
  endtask

  task automatic accept();
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    chk("valid_cleared", vector_valid, 1'b0);
  endtask

  int lat, pulses, lows, lowc, guard;
  logic [7:0] v;
  logic [15:0] ca;
  logic sp;

  initial begin
    #1 reset = 1'b1;
    #2;
    chk("rst_inta_n", inta_n, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", vector_valid, 1'b0);
    chk("rst_vector", vector, 8'h00);
    chk("rst_call", call_address, 16'h0000);
    chk("rst_spurious", spurious, 1'b0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;

    // 8086, type 0x48 on the second pulse
    run_seq(1'b0, 8'h00, 8'h48, 8'h00, 3'b010, 1'b0, lat, pulses, lows, v, ca, sp);
    chk("t1_latency", lat, 17);
    chk("t1_pulses", pulses, 2);
    chk("t1_low_clks", lows, 8);
    chk("t1_vector", v, 8'h48);
    chk("t1_call", ca, 16'h0120);
    chk("t1_spur", sp, 1'b0);
    accept();

    // MCS-80, CALL 1234h
    run_seq(1'b1, 8'hCD, 8'h34, 8'h12, 3'b111, 1'b0, lat, pulses, lows, v, ca, sp);
    chk("t2_latency", lat, 25);
    chk("t2_pulses", pulses, 3);
    chk("t2_low_clks", lows, 12);
    chk("t2_vector", v, 8'h34);
    chk("t2_call", ca, 16'h1234);
    chk("t2_spur", sp, 1'b0);
    accept();

    // MCS-80, bad opcode byte
    run_seq(1'b1, 8'h00, 8'h34, 8'h12, 3'b111, 1'b0, lat, pulses, lows, v, ca, sp);
    chk("t3_pulses", pulses, 3);
    chk("t3_vector", v, 8'hFF);
    chk("t3_call", ca, 16'hFFFF);
    chk("t3_spur", sp, 1'b1);
    accept();

    // 8086, nobody drives the type byte
    run_seq(1'b0, 8'h00, 8'h48, 8'h00, 3'b000, 1'b0, lat, pulses, lows, v, ca, sp);
    chk("t4_spur", sp, 1'b1);
    chk("t4_vector", v, 8'hFF);
    accept();

    // 8086, INTR withdrawn after the first pulse
    run_seq(1'b0, 8'h00, 8'h48, 8'h00, 3'b010, 1'b1, lat, pulses, lows, v, ca, sp);
    chk("t5_pulses", pulses, 2);
    chk("t5_spur", sp, 1'b1);
    chk("t5_call", ca, 16'hFFFF);
    accept();

    // Back-pressure: hold ready low 10 clocks with INTR still asserted
    run_seq(1'b0, 8'h00, 8'h20, 8'h00, 3'b010, 1'b0, lat, pulses, lows, v, ca, sp);
    intr = 1'b1; ie = 1'b1; mode = 1'b0;
    lowc = 0;
    repeat (10) begin
      @(negedge clock);
      if (!inta_n) lowc++;
    end
    chk("t6_no_inta_while_held", lowc, 0);
    chk("t6_valid_held", vector_valid, 1'b1);
    chk("t6_vector_held", vector, 8'h20);
    chk("t6_call_held", call_address, 16'h0080);
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
    chk("t6_valid_cleared", vector_valid, 1'b0);
    chk("t6_idle_dwell_busy", busy, 1'b0);
    chk("t6_idle_dwell_inta", inta_n, 1'b1);
    @(negedge clock);
    chk("t6_restart_inta", inta_n, 1'b0);
    intr = 1'b0; ie = 1'b0;
    ready = 1'b1;
    guard = 0;
    while (busy && guard < 100) begin @(negedge clock); guard++; end
    chk("t6_drain", busy, 1'b0);
    ready = 1'b0;

    // Reset during the LOW phase of pulse 1
    @(negedge clock);
    intr = 1'b1; ie = 1'b1; mode = 1'b0;
    pulses = 0; guard = 0;
    begin
      bit prev = 1'b1;
      while (pulses < 2 && guard < 100) begin
        @(negedge clock);
        guard++;
        if (prev && !inta_n) pulses++;
        prev = inta_n;
      end
    end
    chk("t7_reached_pulse1", pulses, 2);
    @(negedge clock);
    chk("t7_inta_low_before_rst", inta_n, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t7_inta_n", inta_n, 1'b1);
    chk("t7_busy", busy, 1'b0);
    chk("t7_valid", vector_valid, 1'b0);
    chk("t7_vector", vector, 8'h00);
    chk("t7_call", call_address, 16'h0000);
    chk("t7_spur", spurious, 1'b0);
    intr = 1'b0; ie = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Interrupts disabled: no acknowledge cycle at all
    intr = 1'b1; ie = 1'b0;
    lowc = 0;
    repeat (30) begin
      @(negedge clock);
      if (!inta_n || busy) lowc++;
    end
    chk("t8_if0_no_inta", lowc, 0);
    intr = 1'b0;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
